// File: rtl/rx_descrambler.sv
// Gen1/Gen2 receive descrambler: 16-bit Galois LFSR (x^16+x^5+x^4+x^3+1), reseeded on COM,
// processing 1/2/4 symbols per pclk with registered outputs.
module rx_descrambler #(
   parameter logic [15:0] SEED    = 16'hFFFF,
   parameter logic [7:0]  COM_SYM = 8'hBC,
   parameter logic [7:0]  SKP_SYM = 8'h1C
) (
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        turnOff,
   input  logic [5:0]  PIPEWIDTH,
   input  logic [31:0] rxDataIn,
   input  logic [3:0]  rxDataK,
   input  logic        rxDataValid,
   output logic [31:0] descramblerDataOut,
   output logic [3:0]  descramblerDataK,
   output logic        descramblerDataValid,
   output logic        lfsrLocked
);

   localparam logic [15:0] TAPS = 16'h0039;

   logic [15:0] lfsr_q, lfsr_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  k_q, k_d;
   logic        valid_q, valid_d;
   logic        locked_q, locked_d;

   logic [3:0]  lane_en;
   logic [31:0] byte_mask;
   logic [15:0] chain;
   logic [7:0]  sym;
   logic [7:0]  key;

   function automatic logic [15:0] step8(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      for (int unsigned j = 0; j < 8; j++) begin
         r = {r[14:0], 1'b0} ^ (r[15] ? TAPS : '0);
      end
      return r;
   endfunction

   // Keystream bit j is the LFSR MSB just before the j-th shift.
   function automatic logic [7:0] key_byte(input logic [15:0] s);
      logic [15:0] r;
      logic [7:0]  kb;
      r  = s;
      kb = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         kb[j] = r[15];
         r     = {r[14:0], 1'b0} ^ (r[15] ? TAPS : '0);
      end
      return kb;
   endfunction

   always_comb begin
      unique case (PIPEWIDTH)
         6'd8:    lane_en = 4'b0001;
         6'd16:   lane_en = 4'b0011;
         6'd32:   lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
      for (int unsigned i = 0; i < 4; i++) begin
         byte_mask[8*i +: 8] = {8{lane_en[i]}};
      end
   end

   always_comb begin
      lfsr_d   = lfsr_q;
      data_d   = '0;
      k_d      = '0;
      valid_d  = rxDataValid;
      locked_d = locked_q;
      chain    = lfsr_q;
      sym      = '0;
      key      = '0;
      if (rxDataValid) begin
         // Unsupported widths still forward the full K flags.
         k_d = (lane_en == '0) ? rxDataK : (rxDataK & lane_en);
         if (turnOff) begin
            data_d = rxDataIn & byte_mask;
         end else if (lane_en != '0) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (lane_en[i]) begin
                  sym = rxDataIn[8*i +: 8];
                  key = key_byte(chain);
                  if (rxDataK[i] && (sym == COM_SYM)) begin
                     data_d[8*i +: 8] = sym;
                     chain            = SEED;
                     locked_d         = 1'b1;
                  end else if (rxDataK[i] && (sym == SKP_SYM)) begin
                     data_d[8*i +: 8] = sym;
                  end else if (rxDataK[i]) begin
                     data_d[8*i +: 8] = sym;
                     chain            = step8(chain);
                  end else begin
                     data_d[8*i +: 8] = sym ^ key;
                     chain            = step8(chain);
                  end
               end
            end
            lfsr_d = chain;
         end
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q   <= SEED;
         data_q   <= '0;
         k_q      <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         data_q   <= data_d;
         k_q      <= k_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
      end
   end

   assign descramblerDataOut   = data_q;
   assign descramblerDataK     = k_q;
   assign descramblerDataValid = valid_q;
   assign lfsrLocked           = locked_q;

endmodule

// File: tb/tb_rx_descrambler.sv
// Bench for rx_descrambler: directed vector table, async reset sequence, then random
// traffic checked against a keystream-position model.
module tb_rx_descrambler;

   logic        pclk = 1'b0;
   logic        reset_n = 1'b1;
   logic        turnOff;
   logic [5:0]  PIPEWIDTH;
   logic [31:0] rxDataIn;
   logic [3:0]  rxDataK;
   logic        rxDataValid;
   logic [31:0] descramblerDataOut;
   logic [3:0]  descramblerDataK;
   logic        descramblerDataValid;
   logic        lfsrLocked;

   int n_cmp = 0;
   int n_bad = 0;

   localparam int LEN = 1024;
   logic [7:0] ks [LEN];
   int         ref_pos;
   bit         ref_locked;

   rx_descrambler #(.SEED(16'hFFFF), .COM_SYM(8'hBC), .SKP_SYM(8'h1C)) dut (
      .pclk                 (pclk),
      .reset_n              (reset_n),
      .turnOff              (turnOff),
      .PIPEWIDTH            (PIPEWIDTH),
      .rxDataIn             (rxDataIn),
      .rxDataK              (rxDataK),
      .rxDataValid          (rxDataValid),
      .descramblerDataOut   (descramblerDataOut),
      .descramblerDataK     (descramblerDataK),
      .descramblerDataValid (descramblerDataValid),
      .lfsrLocked           (lfsrLocked)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [5:0]  w;
      logic        t;
      logic        v;
      logic [3:0]  k;
      logic [31:0] d;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic        ev;
      logic        el;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [37:0] exp);
      logic [37:0] act;
      act = {descramblerDataOut, descramblerDataK, descramblerDataValid, lfsrLocked};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got data=%h k=%b v=%b lock=%b, want data=%h k=%b v=%b lock=%b",
                  name, act[37:6], act[5:2], act[1], act[0], exp[37:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic drive(input logic [5:0] w, input logic t, input logic v,
                        input logic [3:0] k, input logic [31:0] d);
      PIPEWIDTH   = w;
      turnOff     = t;
      rxDataValid = v;
      rxDataK     = k;
      rxDataIn    = d;
   endtask

   task automatic apply(input logic [5:0] w, input logic t, input logic v,
                        input logic [3:0] k, input logic [31:0] d);
      drive(w, t, v, k, d);
      @(posedge pclk);
      #1;
   endtask

   // Reference: the keystream is a fixed byte sequence from the seed; the descrambler
   // state is just a position in it (COM -> 0, SKP -> stay, other symbol -> +1).
   task automatic ref_step(input logic [5:0] w, input logic t, input logic v,
                           input logic [3:0] k, input logic [31:0] d,
                           output logic [37:0] exp);
      int          n;
      logic [31:0] od;
      logic [3:0]  ok;
      logic [7:0]  b;
      n  = (w == 6'd8) ? 1 : (w == 6'd16) ? 2 : (w == 6'd32) ? 4 : 0;
      od = '0;
      ok = '0;
      if (v) begin
         for (int i = 0; i < 4; i++) if (i < n || n == 0) ok[i] = k[i];
         if (t) begin
            for (int i = 0; i < n; i++) od[8*i +: 8] = d[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) begin
               b = d[8*i +: 8];
               if (k[i] && b == 8'hBC) begin
                  od[8*i +: 8] = b;
                  ref_pos = 0;
                  ref_locked = 1'b1;
               end else if (k[i] && b == 8'h1C) begin
                  od[8*i +: 8] = b;
               end else if (k[i]) begin
                  od[8*i +: 8] = b;
                  ref_pos++;
               end else begin
                  od[8*i +: 8] = b ^ ks[ref_pos];
                  ref_pos++;
               end
            end
         end
      end
      exp = {od, ok, v, ref_locked};
   endtask

   function automatic logic [7:0] rand_sym(output logic kf);
      int r;
      r = $urandom_range(0, 99);
      if (r < 15)      begin kf = 1'b1; return 8'hBC; end
      else if (r < 25) begin kf = 1'b1; return 8'h1C; end
      else if (r < 30) begin kf = 1'b1; return 8'($urandom); end
      kf = 1'b0;
      return 8'($urandom);
   endfunction

   initial begin
      logic [37:0] exp;
      logic [5:0]  w;
      logic        t, v, kf;
      logic [3:0]  k;
      logic [31:0] d;
      int          st, r;

      st = 16'hFFFF;
      for (int p = 0; p < LEN; p++) begin
         logic [7:0] kb;
         kb = '0;
         for (int j = 0; j < 8; j++) begin
            kb[j] = st[15];
            st = st << 1;
            if (st & 32'h10000) st = st ^ 32'h10039;
         end
         ks[p] = kb;
      end

      //                 w    t  v  k        d              exp data       ek       ev  el
      tbl.push_back('{6'd8,  0, 1, 4'b0001, 32'h000000BC, 32'h000000BC, 4'b0001, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0000, 32'h00000000, 32'h000000FF, 4'b0000, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0000, 32'h00000000, 32'h00000017, 4'b0000, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0000, 32'h00000000, 32'h000000C0, 4'b0000, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0000, 32'h00000000, 32'h00000014, 4'b0000, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0001, 32'h000000BC, 32'h000000BC, 4'b0001, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0000, 32'h00000000, 32'h000000FF, 4'b0000, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0001, 32'h0000001C, 32'h0000001C, 4'b0001, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0001, 32'h0000001C, 32'h0000001C, 4'b0001, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0000, 32'h00000000, 32'h00000017, 4'b0000, 1, 1});
      tbl.push_back('{6'd32, 0, 1, 4'b0001, 32'h000000BC, 32'hC017FFBC, 4'b0001, 1, 1});
      tbl.push_back('{6'd32, 0, 1, 4'b0000, 32'h00000000, 32'h02E7B214, 4'b0000, 1, 1});
      tbl.push_back('{6'd16, 0, 1, 4'b0001, 32'h000000BC, 32'h0000FFBC, 4'b0001, 1, 1});
      tbl.push_back('{6'd16, 0, 0, 4'b1111, 32'h12345678, 32'h00000000, 4'b0000, 0, 1});
      tbl.push_back('{6'd16, 0, 0, 4'b1111, 32'h12345678, 32'h00000000, 4'b0000, 0, 1});
      tbl.push_back('{6'd16, 0, 0, 4'b1111, 32'h12345678, 32'h00000000, 4'b0000, 0, 1});
      tbl.push_back('{6'd16, 0, 1, 4'b0000, 32'h00000000, 32'h0000C017, 4'b0000, 1, 1});
      tbl.push_back('{6'd32, 1, 1, 4'b0000, 32'h0000A5A5, 32'h0000A5A5, 4'b0000, 1, 1});
      tbl.push_back('{6'd16, 1, 1, 4'b1100, 32'hFFFFA5A5, 32'h0000A5A5, 4'b0000, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0000, 32'h00000000, 32'h00000014, 4'b0000, 1, 1});
      tbl.push_back('{6'd24, 0, 1, 4'b1010, 32'h00000055, 32'h00000000, 4'b1010, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b1110, 32'hFFFFFF00, 32'h000000B2, 4'b0000, 1, 1});
      tbl.push_back('{6'd32, 0, 1, 4'b0101, 32'h00BC00BC, 32'hFFBCFFBC, 4'b0101, 1, 1});
      tbl.push_back('{6'd32, 0, 1, 4'b0100, 32'h00BC0000, 32'hFFBCC017, 4'b0100, 1, 1});
      tbl.push_back('{6'd16, 0, 1, 4'b0001, 32'h000000F7, 32'h0000C0F7, 4'b0001, 1, 1});
      tbl.push_back('{6'd8,  1, 1, 4'b0001, 32'h000000BC, 32'h000000BC, 4'b0001, 1, 1});
      tbl.push_back('{6'd8,  0, 1, 4'b0000, 32'h00000000, 32'h00000014, 4'b0000, 1, 1});

      // Reset with active inputs must clear outputs before any clock edge.
      drive(6'd32, 1'b0, 1'b1, 4'b0001, 32'h000000BC);
      #1 reset_n = 1'b0;
      #1 check("reset_no_edge", '0);
      @(posedge pclk);
      #1 check("reset_held", '0);
      @(negedge pclk);
      reset_n = 1'b1;
      apply(6'd8, 1'b0, 1'b0, 4'b0000, 32'h00000000);
      check("idle_after_reset", '0);

      foreach (tbl[i]) begin
         apply(tbl[i].w, tbl[i].t, tbl[i].v, tbl[i].k, tbl[i].d);
         check($sformatf("vec%0d", i), {tbl[i].ed, tbl[i].ek, tbl[i].ev, tbl[i].el});
      end

      // Reset pulsed mid-cycle while traffic is active.
      apply(6'd32, 1'b0, 1'b1, 4'b0000, 32'hDEADBEEF);
      #3 reset_n = 1'b0;
      #1 check("async_reset_mid", '0);
      @(negedge pclk);
      reset_n = 1'b1;
      apply(6'd32, 1'b0, 1'b0, 4'b0000, 32'h00000000);
      check("idle_after_mid_reset", '0);

      ref_pos = 0;
      ref_locked = 1'b0;
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(0, 99);
         w = (r < 30) ? 6'd8 : (r < 60) ? 6'd16 : (r < 95) ? 6'd32 : 6'd24;
         t = ($urandom_range(0, 9) == 0);
         v = ($urandom_range(0, 99) < 85);
         for (int i = 0; i < 4; i++) begin
            d[8*i +: 8] = rand_sym(kf);
            k[i] = kf;
         end
         if (ref_pos > LEN - 8) begin
            d[7:0] = 8'hBC;
            k[0]   = 1'b1;
            v      = 1'b1;
            t      = 1'b0;
            if (w == 6'd24) w = 6'd8;
         end
         ref_step(w, t, v, k, d, exp);
         apply(w, t, v, k, d);
         check($sformatf("rand%0d", c), exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
